// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the round-robin req/ack handshake arbiter.
package hs_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int TMO_W_DEF     = 8;
    localparam int TMO_LIMIT_DEF = 200;

endpackage

// File: rtl/hs_arbiter_sva.sv
// Protocol checks for hs_arbiter, bound onto every instance.
module hs_arbiter_sva
    import hs_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TMO_LIMIT = TMO_LIMIT_DEF
) (
    input logic            clk,
    input logic            rstn,
    input logic [2:0]      state,
    input logic            req,
    input logic            busy,
    input logic [NREQ-1:0] done,
    input logic [NREQ-1:0] fail
);

    int unsigned wcnt_q;

    // wcnt_q counts WAIT cycles already spent before the current one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wcnt_q <= 0;
        end else begin
            wcnt_q <= (state == WAIT) ? wcnt_q + 1 : 0;
            assert (!(|done && |fail));
            assert ($onehot0(done));
            assert ($onehot0(fail));
            assert (!req || busy);
            if (state == WAIT) begin
                assert (wcnt_q < TMO_LIMIT);
            end
        end
    end

endmodule

bind hs_arbiter hs_arbiter_sva #(
    .NREQ      (NREQ),
    .TMO_LIMIT (TMO_LIMIT)
) u_sva (
    .clk   (clk),
    .rstn  (rstn),
    .state (state_q),
    .req   (req),
    .busy  (busy),
    .done  (done),
    .fail  (fail)
);

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW:0] sum;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (req_i[sum[IW-1:0]]) begin
                idx_o   = sum[IW-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_arbiter.sv
// Shares one req/ack target between NREQ clients, one transaction at a time,
// with a WAIT timeout and per-client done/fail pulses.
module hs_arbiter
    import hs_arb_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int TMO_W     = TMO_W_DEF,
    parameter  int TMO_LIMIT = TMO_LIMIT_DEF,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] start,
    input  logic            ack,
    output logic            req,
    output logic [IW-1:0]   gnt_id,
    output logic            busy,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] fail,
    output logic [TMO_W-1:0] timer
);

    localparam logic [IW-1:0]    LAST    = IW'(NREQ - 1);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO_LIMIT - 1);

    state_t           state_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    gnt_q;
    logic [TMO_W-1:0] timer_q;

    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic [IW-1:0]    ptr_nxt;
    logic [NREQ-1:0]  gnt_oh;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (start),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    assign ptr_nxt = (gnt_q == LAST) ? '0 : gnt_q + IW'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            timer_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_idx;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                // Expiry wins over an ack arriving in the final WAIT cycle.
                WAIT: begin
                    if (timer_q == TMO_END) begin
                        state_q <= ERR;
                    end else if (ack) begin
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q + TMO_W'(1);
                    end
                end
                DONE, ERR: begin
                    rr_ptr_q <= ptr_nxt;
                    state_q  <= IDLE;
                end
                default: state_q <= ERR;
            endcase
        end
    end

    assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;

    assign req    = (state_q == REQ) || (state_q == WAIT);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) ? gnt_oh : '0;
    assign fail   = (state_q == ERR)  ? gnt_oh : '0;
    assign gnt_id = gnt_q;
    assign timer  = timer_q;

endmodule
